// File: rtl/gate_preact_mac.sv
`default_nettype none
// gate_preact_mac: streamed signed dot product plus bias with round-half-up and saturation.
// Rev 1.0
module gate_preact_mac #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRACT_WIDTH = 8,
  parameter int N_IN        = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_v,
  input  logic [DATA_WIDTH-1:0] in_w,
  input  logic                  in_last,
  input  logic [DATA_WIDTH-1:0] in_bias,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sat,
  output logic                  out_len_err
);

  localparam int ACC_W = 2*DATA_WIDTH + $clog2(N_IN) + 1;
  localparam int SUM_W = ACC_W + 1;
  localparam int CNT_W = $clog2(N_IN + 1);
  localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N_IN);
  localparam logic signed [SUM_W-1:0] HALF_LSB = SUM_W'(1) << (FRACT_WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  logic [1:0]                   state_q, state_d;
  logic                         in_ready_q, in_ready_d;
  logic                         out_valid_q, out_valid_d;
  logic signed [ACC_W-1:0]      acc_q;
  logic [CNT_W-1:0]             cnt_q;
  logic signed [DATA_WIDTH-1:0] bias_q;
  logic                         len_err_q;
  logic [DATA_WIDTH-1:0]        out_data_q;
  logic                         out_sat_q, out_len_err_q;

  logic                           w_accept, w_close, w_len_err, w_ovf;
  logic [CNT_W-1:0]               w_cnt_nxt;
  logic signed [2*DATA_WIDTH-1:0] w_prod;
  logic signed [ACC_W-1:0]        w_prod_ext;
  logic signed [SUM_W-1:0]        w_sum, w_rnd;
  logic [DATA_WIDTH-1:0]          w_clamped;

  assign w_accept   = in_valid && in_ready_q;
  assign w_prod     = $signed(in_v) * $signed(in_w);
  assign w_prod_ext = ACC_W'(w_prod);
  assign w_cnt_nxt  = (state_q == S_IDLE) ? CNT_W'(1) : cnt_q + 1'b1;
  assign w_close    = w_accept && (in_last || (w_cnt_nxt == N_LAST));
  // Closing without in_last can only happen at cnt==N_IN, which is itself an error.
  assign w_len_err  = in_last ? (w_cnt_nxt != N_LAST) : 1'b1;

  assign w_sum = SUM_W'(acc_q) + (SUM_W'(bias_q) <<< FRACT_WIDTH) + HALF_LSB;
  assign w_rnd = w_sum >>> FRACT_WIDTH;
  // In range iff all bits from the result sign bit upward agree.
  assign w_ovf = !((&w_rnd[SUM_W-1:DATA_WIDTH-1]) || !(|w_rnd[SUM_W-1:DATA_WIDTH-1]));
  assign w_clamped = !w_ovf ? w_rnd[DATA_WIDTH-1:0] :
                     w_rnd[SUM_W-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} :
                                      {1'b0, {(DATA_WIDTH-1){1'b1}}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_ACC: begin
        if (w_close)       state_d = S_FIN;
        else if (w_accept) state_d = S_ACC;
      end
      S_FIN:   state_d = S_OUT;
      S_OUT:   if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready_d  = (state_d == S_IDLE) || (state_d == S_ACC);
    out_valid_d = (state_d == S_OUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q         <= '0;
      cnt_q         <= '0;
      bias_q        <= '0;
      len_err_q     <= 1'b0;
      out_data_q    <= '0;
      out_sat_q     <= 1'b0;
      out_len_err_q <= 1'b0;
    end else begin
      if (w_accept) begin
        cnt_q <= w_cnt_nxt;
        if (state_q == S_IDLE) begin
          acc_q     <= w_prod_ext;
          bias_q    <= $signed(in_bias);
          len_err_q <= 1'b0;
        end else begin
          acc_q <= acc_q + w_prod_ext;
        end
        if (w_close) len_err_q <= w_len_err;
      end
      if (state_q == S_FIN) begin
        out_data_q    <= w_clamped;
        out_sat_q     <= w_ovf;
        out_len_err_q <= len_err_q;
      end
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_sat     = out_sat_q;
  assign out_len_err = out_len_err_q;

endmodule
`default_nettype wire
